// File: rtl/dbg_uart_bridge_pkg.sv
// Shared definitions for the UART debug bridge: host command opcodes,
// bridge FSM states, default transmit pacing and the byte-lane helper.
package dbg_uart_bridge_pkg;

    // One 10-bit frame at 115200 Bd from a 50 MHz clock.
    localparam int TX_GAP_DEFAULT = 4340;

    localparam logic [7:0] CMD_SETA = 8'h01;
    localparam logic [7:0] CMD_READ = 8'h02;
    localparam logic [7:0] CMD_WRW  = 8'h03;
    localparam logic [7:0] CMD_WRB  = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG1,
        ST_ARG2,
        ST_ACC1,
        ST_ACC2,
        ST_TXH,
        ST_TXL
    } state_t;

    // Byte enable for a byte write: even address -> bits 15:8, odd -> bits 7:0.
    function automatic logic [1:0] byte_en(input logic a0);
        return a0 ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/dbg_tx_pacer.sv
// Transmit pacer for the debug bridge.
// A load request latches a byte onto o_od and issues a one-cycle o_dox strobe
// in the following clock. o_done is high in the last clock of the TX_GAP window
// that starts with that strobe, so a load issued while o_done is high produces
// the next strobe exactly TX_GAP clocks after the previous one.
//   clk, reset : clock, asynchronous active-high reset
//   i_load     : one-cycle request to send i_byte
//   i_byte     : byte to send
//   o_dox      : transmit strobe
//   o_od       : transmitted byte, held until the next load
//   o_done     : pacing window has elapsed
module dbg_tx_pacer
    import dbg_uart_bridge_pkg::*;
#(
    parameter int TX_GAP = TX_GAP_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_dox,
    output logic [7:0] o_od,
    output logic       o_done
);

    localparam int CW = $clog2(TX_GAP + 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(TX_GAP - 1);

    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_dox;
    logic [7:0]    r_od;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_dox  <= 1'b0;
            r_od   <= 8'h00;
        end else begin
            r_dox <= i_load;
            if (i_load) begin
                r_od   <= i_byte;
                r_cnt  <= GAP_LAST;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_cnt == '0) r_busy <= 1'b0;
                else             r_cnt  <= r_cnt - 1'b1;
            end
        end
    end

    assign o_dox  = r_dox;
    assign o_od   = r_od;
    assign o_done = r_busy && (r_cnt == '0);

endmodule

// File: rtl/dbg_uart_bridge.sv
// Byte-stream debug monitor between the UART byte interface and the b16
// memory bus. Host bytes are decoded into SETA / READ / WRW / WRB commands;
// each access holds the bus (csu) for exactly two clocks, and READ results are
// sent back high byte first through the paced transmitter.
//   clk, reset : clock, asynchronous active-high reset
//   dix, id    : received-byte strobe and byte
//   dox, od    : transmit strobe and byte
//   csu        : bus ownership while an access is in progress
//   addr       : bus byte address (current address register)
//   r, w       : read strobe, write byte enables ([1] = bits 15:8)
//   rdata      : read data from the bus
//   wdata      : write data
module dbg_uart_bridge
    import dbg_uart_bridge_pkg::*;
#(
    parameter int TX_GAP = TX_GAP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dix,
    input  logic [7:0]  id,
    output logic        dox,
    output logic [7:0]  od,
    output logic        csu,
    output logic [15:0] addr,
    output logic        r,
    output logic [1:0]  w,
    input  logic [15:0] rdata,
    output logic [15:0] wdata
);

    state_t      r_state;
    logic [7:0]  r_cmd;
    logic [7:0]  r_hi;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_csu;
    logic        r_rd;
    logic [1:0]  r_we;
    logic        r_word;      // word access in flight: present the aligned address
    logic [7:0]  r_shadow_lo; // high byte goes straight to the pacer in ACC2

    logic        w_load;
    logic [7:0]  w_txbyte;
    logic        w_done;
    logic [15:0] w_addr_next;

    assign w_addr_next = r_addr + ((r_cmd == CMD_WRB) ? 16'd1 : 16'd2);

    // High byte is loaded from the live bus at the end of ACC2 so its strobe
    // lands in the first TXH clock; the low byte follows when the gap expires.
    assign w_load   = ((r_state == ST_ACC2) && (r_cmd == CMD_READ)) ||
                      ((r_state == ST_TXH) && w_done);
    assign w_txbyte = (r_state == ST_ACC2) ? rdata[15:8] : r_shadow_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cmd       <= 8'h00;
            r_hi        <= 8'h00;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_csu       <= 1'b0;
            r_rd        <= 1'b0;
            r_we        <= 2'b00;
            r_word      <= 1'b0;
            r_shadow_lo <= 8'h00;
        end else begin
            unique case (r_state)
                ST_IDLE: if (dix) begin
                    case (id)
                        CMD_SETA, CMD_WRW, CMD_WRB: begin
                            r_cmd   <= id;
                            r_state <= ST_ARG1;
                        end
                        CMD_READ: begin
                            r_cmd   <= id;
                            r_csu   <= 1'b1;
                            r_rd    <= 1'b1;
                            r_word  <= 1'b1;
                            r_state <= ST_ACC1;
                        end
                        default: ;
                    endcase
                end
                ST_ARG1: if (dix) begin
                    if (r_cmd == CMD_WRB) begin
                        r_wdata <= {id, id};
                        r_we    <= byte_en(r_addr[0]);
                        r_csu   <= 1'b1;
                        r_state <= ST_ACC1;
                    end else begin
                        r_hi    <= id;
                        r_state <= ST_ARG2;
                    end
                end
                ST_ARG2: if (dix) begin
                    if (r_cmd == CMD_SETA) begin
                        r_addr  <= {r_hi, id};
                        r_state <= ST_IDLE;
                    end else begin
                        r_wdata <= {r_hi, id};
                        r_we    <= 2'b11;
                        r_csu   <= 1'b1;
                        r_word  <= 1'b1;
                        r_state <= ST_ACC1;
                    end
                end
                ST_ACC1: r_state <= ST_ACC2;
                ST_ACC2: begin
                    r_csu  <= 1'b0;
                    r_rd   <= 1'b0;
                    r_we   <= 2'b00;
                    r_word <= 1'b0;
                    r_addr <= w_addr_next;
                    if (r_cmd == CMD_READ) begin
                        r_shadow_lo <= rdata[7:0];
                        r_state     <= ST_TXH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_TXH: if (w_done) r_state <= ST_TXL;
                ST_TXL: if (w_done) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    dbg_tx_pacer #(.TX_GAP(TX_GAP)) u_pacer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_byte (w_txbyte),
        .o_dox  (dox),
        .o_od   (od),
        .o_done (w_done)
    );

    assign csu   = r_csu;
    assign r     = r_rd;
    assign w     = r_we;
    assign wdata = r_wdata;
    assign addr  = r_word ? {r_addr[15:1], 1'b0} : r_addr;

endmodule

// File: tb/tb_dbg_uart_bridge.sv
// Self-checking bench for dbg_uart_bridge: constant vector table, hand-written
// busy/reset sequences, then random commands against a command-level model.
module tb_dbg_uart_bridge;
    import dbg_uart_bridge_pkg::*;

    localparam int GAP = 24;

    logic        clk = 1'b0;
    logic        reset, dix, dox, csu, r;
    logic [7:0]  id, od;
    logic [15:0] addr, rdata, wdata;
    logic [1:0]  w;

    always #5 clk = ~clk;

    dbg_uart_bridge #(.TX_GAP(GAP)) dut (
        .clk(clk), .reset(reset), .dix(dix), .id(id), .dox(dox), .od(od),
        .csu(csu), .addr(addr), .r(r), .w(w), .rdata(rdata), .wdata(wdata)
    );

    // Bus memory, written by the DUT's own bus cycles.
    logic [15:0] bmem [0:32767];
    logic        mem_clr;
    assign rdata = bmem[addr[15:1]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32768; i++) bmem[i] <= 16'h0000;
        end else if (csu) begin
            if (w[1]) bmem[addr[15:1]][15:8] <= wdata[15:8];
            if (w[0]) bmem[addr[15:1]][7:0]  <= wdata[7:0];
        end
    end

    // Observation of bus and tx activity since the last clear.
    int          cyc = 0, epoch = 0, seen_epoch = 0;
    int          csu_n, tx_n, t0, t1;
    logic [15:0] a_addr, a_wdata;
    logic        a_r, a_bad;
    logic [1:0]  a_w;
    logic [7:0]  tx0, tx1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (epoch != seen_epoch) begin
            seen_epoch <= epoch;
            csu_n <= 0; tx_n <= 0; a_bad <= 1'b0;
        end else if (!reset) begin
            if (csu) begin
                csu_n <= csu_n + 1;
                if (csu_n == 0) begin
                    a_addr <= addr; a_r <= r; a_w <= w; a_wdata <= wdata;
                end else if ({addr, r, w, wdata} != {a_addr, a_r, a_w, a_wdata}) begin
                    a_bad <= 1'b1;
                end
            end else if (r || (w != 2'b00)) begin
                a_bad <= 1'b1;
            end
            if (dox) begin
                if (tx_n == 0) begin tx0 <= od; t0 <= cyc; end
                else if (tx_n == 1) begin tx1 <= od; t1 <= cyc; end
                tx_n <= tx_n + 1;
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  b0, b1, b2;
        int          n;
        int          csu_n;
        logic [15:0] baddr;
        logic        r;
        logic [1:0]  w;
        logic [15:0] wdata;
        int          tx_n;
        logic [7:0]  tx0, tx1;
        logic [15:0] addr;
    } vec_t;

    task automatic clear_obs();
        epoch++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        dix = 1'b1; id = b;
        @(negedge clk);
        dix = 1'b0;
    endtask

    task automatic run_cmd(input vec_t v);
        clear_obs();
        send_byte(v.b0);
        if (v.n > 1) send_byte(v.b1);
        if (v.n > 2) send_byte(v.b2);
        repeat ((v.b0 == CMD_READ) ? 2 * GAP + 8 : 6) @(negedge clk);
    endtask

    task automatic check_obs(input vec_t v, input string tag);
        check({tag, "_csu_clocks"}, csu_n, v.csu_n);
        if (v.csu_n > 0) begin
            check({tag, "_bus_addr"}, a_addr, v.baddr);
            check({tag, "_r"}, a_r, v.r);
            check({tag, "_w"}, a_w, v.w);
            check({tag, "_bus_stable"}, a_bad, 0);
            if (v.w != 2'b00) check({tag, "_wdata"}, a_wdata, v.wdata);
        end
        check({tag, "_tx_count"}, tx_n, v.tx_n);
        if (v.tx_n == 2) begin
            check({tag, "_tx_hi"}, tx0, v.tx0);
            check({tag, "_tx_lo"}, tx1, v.tx1);
            check({tag, "_tx_gap"}, t1 - t0, GAP);
        end
        check({tag, "_addr"}, addr, v.addr);
    endtask

    // Command-level reference model.
    logic [15:0] mmem [0:32767];
    logic [15:0] maddr;

    task automatic model_cmd(input logic [7:0] b0, b1, b2, input int n, output vec_t e);
        logic [15:0] a;
        e = '{b0, b1, b2, n, 0, 16'h0, 1'b0, 2'b00, 16'h0, 0, 8'h0, 8'h0, 16'h0};
        a = {maddr[15:1], 1'b0};
        case (b0)
            CMD_SETA: maddr = {b1, b2};
            CMD_READ: begin
                e.csu_n = 2; e.baddr = a; e.r = 1'b1; e.tx_n = 2;
                e.tx0 = mmem[a[15:1]][15:8]; e.tx1 = mmem[a[15:1]][7:0];
                maddr = maddr + 16'd2;
            end
            CMD_WRW: begin
                e.csu_n = 2; e.baddr = a; e.w = 2'b11; e.wdata = {b1, b2};
                mmem[a[15:1]] = {b1, b2};
                maddr = maddr + 16'd2;
            end
            CMD_WRB: begin
                e.csu_n = 2; e.baddr = maddr; e.wdata = {b1, b1};
                if (maddr[0]) begin e.w = 2'b01; mmem[maddr[15:1]][7:0] = b1; end
                else          begin e.w = 2'b10; mmem[maddr[15:1]][15:8] = b1; end
                maddr = maddr + 16'd1;
            end
            default: ;
        endcase
        e.addr = maddr;
    endtask

    vec_t vt [0:14];

    initial begin
        vec_t        e, v;
        logic [7:0]  b0, b1, b2;
        int          n, k;

        vt[0]  = '{8'h01, 8'h12, 8'h34, 3, 0, 16'h0000, 1'b0, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 16'h1234};
        vt[1]  = '{8'h01, 8'h20, 8'h00, 3, 0, 16'h0000, 1'b0, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 16'h2000};
        vt[2]  = '{8'h03, 8'hBE, 8'hEF, 3, 2, 16'h2000, 1'b0, 2'b11, 16'hBEEF, 0, 8'h00, 8'h00, 16'h2002};
        vt[3]  = '{8'h01, 8'h20, 8'h00, 3, 0, 16'h0000, 1'b0, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 16'h2000};
        vt[4]  = '{8'h02, 8'h00, 8'h00, 1, 2, 16'h2000, 1'b1, 2'b00, 16'h0000, 2, 8'hBE, 8'hEF, 16'h2002};
        vt[5]  = '{8'h01, 8'h30, 8'h01, 3, 0, 16'h0000, 1'b0, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 16'h3001};
        vt[6]  = '{8'h04, 8'h5A, 8'h00, 2, 2, 16'h3001, 1'b0, 2'b01, 16'h5A5A, 0, 8'h00, 8'h00, 16'h3002};
        vt[7]  = '{8'h01, 8'h30, 8'h00, 3, 0, 16'h0000, 1'b0, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 16'h3000};
        vt[8]  = '{8'h04, 8'hA5, 8'h00, 2, 2, 16'h3000, 1'b0, 2'b10, 16'hA5A5, 0, 8'h00, 8'h00, 16'h3001};
        vt[9]  = '{8'h01, 8'h30, 8'h00, 3, 0, 16'h0000, 1'b0, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 16'h3000};
        vt[10] = '{8'h02, 8'h00, 8'h00, 1, 2, 16'h3000, 1'b1, 2'b00, 16'h0000, 2, 8'hA5, 8'h5A, 16'h3002};
        vt[11] = '{8'h01, 8'hFF, 8'hFE, 3, 0, 16'h0000, 1'b0, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 16'hFFFE};
        vt[12] = '{8'h03, 8'h00, 8'h00, 3, 2, 16'hFFFE, 1'b0, 2'b11, 16'h0000, 0, 8'h00, 8'h00, 16'h0000};
        vt[13] = '{8'hFF, 8'h00, 8'h00, 1, 0, 16'h0000, 1'b0, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 16'h0000};
        vt[14] = '{8'h00, 8'h00, 8'h00, 1, 0, 16'h0000, 1'b0, 2'b00, 16'h0000, 0, 8'h00, 8'h00, 16'h0000};

        reset = 1'b1; dix = 1'b0; id = 8'h00; mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dox", dox, 0);
        check("rst_od", od, 0);
        check("rst_csu", csu, 0);
        check("rst_addr", addr, 0);
        check("rst_r", r, 0);
        check("rst_w", w, 0);
        check("rst_wdata", wdata, 0);
        mem_clr = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_cmd(vt[i]);
            check_obs(vt[i], $sformatf("vec%0d", i));
        end

        // A byte arriving between the two tx bytes is dropped.
        v = vt[3]; run_cmd(v);
        clear_obs();
        send_byte(CMD_READ);
        k = 0;
        while (tx_n < 1 && k < 20) begin @(negedge clk); k++; end
        check("busy_first_tx_seen", tx_n >= 1, 1);
        repeat (GAP / 2) @(negedge clk);
        send_byte(CMD_SETA);
        repeat (2 * GAP + 8) @(negedge clk);
        check_obs(vt[4], "busy");
        v = '{8'h01, 8'h40, 8'h00, 3, 0, 16'h0, 1'b0, 2'b00, 16'h0, 0, 8'h0, 8'h0, 16'h4000};
        run_cmd(v);
        check_obs(v, "after_busy");

        // Reset in the middle of a command.
        clear_obs();
        send_byte(CMD_SETA);
        send_byte(8'h12);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midcmd_od", od, 0);
        check("midcmd_addr", addr, 0);
        check("midcmd_csu", csu, 0);
        check("midcmd_dox", dox, 0);
        check("midcmd_wdata", wdata, 0);
        @(negedge clk);
        reset = 1'b0;
        v = '{8'h01, 8'h00, 8'h10, 3, 0, 16'h0, 1'b0, 2'b00, 16'h0, 0, 8'h0, 8'h0, 16'h0010};
        run_cmd(v);
        check_obs(v, "after_reset");

        // Reset during an access drops the bus grant without waiting for a clock.
        send_byte(CMD_WRW); send_byte(8'h11); send_byte(8'h22);
        check("acc_csu_before_reset", {csu, w}, 3'b111);
        #2 reset = 1'b1;
        #1;
        check("async_drop", {csu, r, w}, 4'b0000);
        @(negedge clk);

        // Random commands against the model, from a clean state.
        mem_clr = 1'b1;
        for (int i = 0; i < 32768; i++) mmem[i] = 16'h0000;
        maddr = 16'h0000;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 9);
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            case (k)
                0, 1, 9: begin
                    b0 = CMD_SETA; n = 3;
                    if (k != 9) b1 = 8'h50 + 8'($urandom_range(0, 1));
                end
                2, 3: begin b0 = CMD_READ; n = 1; end
                4, 5: begin b0 = CMD_WRW; n = 3; end
                6, 7: begin b0 = CMD_WRB; n = 2; end
                default: begin
                    b0 = 8'($urandom_range(0, 251));
                    if (b0 != 8'h00) b0 = b0 + 8'd4;
                    n = 1;
                end
            endcase
            model_cmd(b0, b1, b2, n, e);
            run_cmd(e);
            check_obs(e, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
